plzwork_axil_regbank: RTL and testbench
=======================================

Name: plzwork_axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; next generation of the fixed 4 x 32-bit plzwork slave.
- Generalised in register count and data width.
- Adds byte-strobe writes, read-only status registers, SLVERR decode, per-register write pulses, and independent AW/W acceptance with backpressure.
- Sits behind the AXI interconnect; fabric logic consumes reg_out and drives hw_status.

Parameters:
- C_DATA_WIDTH, 32, AXI data width; 32 or 64.
- C_ADDR_WIDTH, 8, AXI address width in bits.
- C_NUM_REGS, 8, number of registers; 1..2**(C_ADDR_WIDTH-ADDR_LSB), where ADDR_LSB = log2(C_DATA_WIDTH/8).
- C_RO_MASK, 0, C_NUM_REGS-bit mask; bit i set makes register i read-only (status).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  C_ADDR_WIDTH  write address; S_AXI_AWPROT in 3 is ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
- S_AXI_WDATA  in  C_DATA_WIDTH  write data
- S_AXI_WSTRB  in  C_DATA_WIDTH/8  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
- S_AXI_ARADDR  in  C_ADDR_WIDTH  read address; S_AXI_ARPROT in 3 is ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
- S_AXI_RDATA  out  C_DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
- reg_out  out  C_NUM_REGS*C_DATA_WIDTH  flattened register contents; register i at slice [i*W +: W]
- reg_wr_pulse  out  C_NUM_REGS  one-cycle pulse when register i is written with OKAY
- hw_status  in  C_NUM_REGS*C_DATA_WIDTH  status source for read-only registers

Behaviour:
- Reset (asynchronous, ARESETN low):
  - AWREADY=1, WREADY=1, ARREADY=1.
  - BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
  - All registers 0, reg_wr_pulse=0, AW/W holding slots empty.
  - Reset mid-transaction drops every pending handshake; no partial write.
- Write path: two one-entry holding slots, AW and W, filled independently.
  - AWREADY = !aw_full; WREADY = !w_full.
  - Commit condition: aw_full and w_full, or the AW and W handshakes on the same edge, and (!BVALID or BREADY).
  - On commit: the register update, BVALID=1 and reg_wr_pulse all take effect on the next edge; both slots then empty.
  - Best-case latency: AW+W in cycle N -> register updated and BVALID at N+1.
  - BVALID holds with stable BRESP until BREADY. No second commit while BVALID and !BREADY, so a stalled B eventually deasserts AWREADY/WREADY.
- Decode: idx = ADDR[ADDR_LSB +: IDX_W]. Address is out of range if idx >= C_NUM_REGS or any bit above the index field is set; low ADDR_LSB bits are ignored.
- Write rules:
  - In range, RW register: byte lane b updated only if WSTRB[b]; BRESP=OKAY(00); pulse.
  - Out of range: no update; BRESP=SLVERR(10); no pulse.
  - RO register: no update; BRESP=SLVERR; no pulse.
- Read path:
  - ARREADY = !RVALID or RREADY. AR handshake at N -> RVALID at N+1.
  - RDATA = RW register value, or registered hw_status slice for RO registers, sampled at the AR edge.
  - Out of range: RDATA=0, RRESP=SLVERR.
  - RDATA/RRESP stable while RVALID and !RREADY.
- Simultaneous read and write to the same register on the same edge: the read returns the pre-write value.
- reg_out is driven from the register flops. RO slices of reg_out show the hw_status value as sampled one cycle earlier.

Optional Feature:
- Macro: PLZWORK_AXIL_W1C_EN.
- Defined:
  - RO registers become sticky status: each bit is set on the cycle hw_status bit is 1.
  - A write with strobe and data bit 1 clears that bit, unless it is also set by hardware on the same edge; set wins.
  - BRESP=OKAY and reg_wr_pulse fires for RO writes.
- Undefined: RO registers track hw_status (one-cycle registered); writes to them give SLVERR as above.

Test Plan:
- Reset: hold ARESETN low 200 ns, release -> all READYs 1, VALIDs 0, all 8 reads return 0x00000000 OKAY.
- Sequential: write 1..8 to 0x00..0x1C, read back -> each read matches, RRESP=00, reg_wr_pulse seen once per register.
- Strobes: reg0=0x12345678, then write 0xFFFFFFFF with WSTRB=4'b0101 -> read 0x12FF56FF.
- Ordering/backpressure:
  - W valid 3 cycles before AW, BREADY low 5 cycles -> BVALID held stable, write commits exactly once.
  - A second AW+W during the stall is held in the slots; READYs go low, and the write commits after BREADY.
- Errors (C_RO_MASK=8'h80, hw_status slice 7=0xA5A5A5A5):
  - Write/read at 0x20 -> SLVERR, RDATA=0, no reg change.
  - Write reg7 -> SLVERR.
  - Read reg7 -> 0xA5A5A5A5.
- W1C (macro defined): pulse hw_status[7] bit0 one cycle -> reg7 reads 0x1. Write 0x1 -> reads 0x0, BRESP=OKAY. Hardware set on the same edge as the clear -> reads 0x1.

Source files
------------

// File: rtl/plzwork_axil_regbank.sv
// AXI4-Lite register bank: AW/W fill one-entry slots, write commits with B one cycle after both arrive; R one cycle after AR.
// A stalled B or R channel backs up into the READYs. Define PLZWORK_AXIL_W1C_EN for sticky write-1-to-clear status registers.
module plzwork_axil_regbank #(
  parameter int                    C_DATA_WIDTH = 32,
  parameter int                    C_ADDR_WIDTH = 8,
  parameter int                    C_NUM_REGS   = 8,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
  output logic [C_NUM_REGS-1:0]              reg_wr_pulse,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] hw_status
);

  localparam int STRB_W   = C_DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int FULL_W   = C_ADDR_WIDTH - ADDR_LSB;
  localparam int IDX_W    = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
`ifdef PLZWORK_AXIL_W1C_EN
  localparam bit W1C_EN = 1'b1;
`else
  localparam bit W1C_EN = 1'b0;
`endif

  logic [C_DATA_WIDTH-1:0] regs [C_NUM_REGS];

  logic                    aw_full, w_full;
  logic [FULL_W-1:0]       aw_addr_q;
  logic [C_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic                    aw_hs, w_hs, commit;
  logic [FULL_W-1:0]       wr_full_addr;
  logic [IDX_W-1:0]        wr_idx;
  logic [C_DATA_WIDTH-1:0] wr_data, wr_mask, wr_clr;
  logic [STRB_W-1:0]       wr_strb;
  logic                    wr_in_range, wr_ro, wr_ok;
  logic [C_NUM_REGS-1:0]   wr_sel;

  logic                    ar_hs;
  logic [FULL_W-1:0]       rd_full_addr;
  logic [IDX_W-1:0]        rd_idx;
  logic                    rd_in_range;
  logic [C_DATA_WIDTH-1:0] rd_val;

  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                    S_AXI_ARADDR[ADDR_LSB-1:0], hw_status};

  assign S_AXI_AWREADY = !aw_full;
  assign S_AXI_WREADY  = !w_full;
  assign aw_hs         = S_AXI_AWVALID && !aw_full;
  assign w_hs          = S_AXI_WVALID && !w_full;
  // A beat arriving this cycle can commit together with the other half already parked.
  assign commit = (aw_full || aw_hs) && (w_full || w_hs) && (!S_AXI_BVALID || S_AXI_BREADY);

  assign wr_full_addr = aw_full ? aw_addr_q : S_AXI_AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
  assign wr_data      = w_full ? w_data_q : S_AXI_WDATA;
  assign wr_strb      = w_full ? w_strb_q : S_AXI_WSTRB;
  assign wr_idx       = wr_full_addr[IDX_W-1:0];
  assign wr_in_range  = 32'(wr_full_addr) < 32'(C_NUM_REGS);
  assign wr_clr       = wr_data & wr_mask;

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < STRB_W; b++) wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
  end

  always_comb begin
    wr_ro  = 1'b0;
    wr_sel = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) wr_ro = C_RO_MASK[i];
    end
    wr_ok = wr_in_range && (!wr_ro || W1C_EN);
    for (int i = 0; i < C_NUM_REGS; i++) begin
      wr_sel[i] = commit && wr_ok && (wr_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= 2'b00;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= wr_sel;
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_full   <= 1'b1;
          aw_addr_q <= S_AXI_AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
        end
        if (w_hs) begin
          w_full   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
      end
      if (commit) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_ok ? 2'b00 : 2'b10;
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Status registers: plain one-cycle copy of hw_status, or sticky with hardware set beating a clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (C_RO_MASK[i]) begin
          if (W1C_EN)
            regs[i] <= (regs[i] & ~(wr_clr & {C_DATA_WIDTH{wr_sel[i]}}))
                       | hw_status[i*C_DATA_WIDTH +: C_DATA_WIDTH];
          else
            regs[i] <= hw_status[i*C_DATA_WIDTH +: C_DATA_WIDTH];
        end else if (wr_sel[i]) begin
          regs[i] <= (regs[i] & ~wr_mask) | wr_clr;
        end
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign reg_out[g*C_DATA_WIDTH +: C_DATA_WIDTH] = regs[g];
  end

  assign S_AXI_ARREADY = !S_AXI_RVALID || S_AXI_RREADY;
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_full_addr  = S_AXI_ARADDR[C_ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx        = rd_full_addr[IDX_W-1:0];
  assign rd_in_range   = 32'(rd_full_addr) < 32'(C_NUM_REGS);

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_val = regs[i];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= 2'b00;
    end else if (ar_hs) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_in_range ? rd_val : '0;
      S_AXI_RRESP  <= rd_in_range ? 2'b00 : 2'b10;
    end else if (S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_plzwork_axil_regbank.sv
// Self-checking bench for plzwork_axil_regbank (8 x 32-bit, register 7 read-only status).
module tb_plzwork_axil_regbank;
  localparam logic [7:0] RO = 8'h80;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [255:0] reg_out, hw_status;
  logic [7:0]   reg_wr_pulse;
  logic [31:0]  hw7;
  logic [223:0] hw_other;

  assign hw_status = {hw7, hw_other};

  plzwork_axil_regbank #(
    .C_DATA_WIDTH(32), .C_ADDR_WIDTH(8), .C_NUM_REGS(8), .C_RO_MASK(RO)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse), .hw_status(hw_status)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] model [8];
  logic [31:0] sticky;
  int exp_pulse [8];
  int pulse_cnt [8];

  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) if (reg_wr_pulse[i]) pulse_cnt[i]++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: value a status register reads back as.
  function automatic logic [31:0] ro_value();
`ifdef PLZWORK_AXIL_W1C_EN
    return sticky;
`else
    return hw7;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [2:0] i3;
    i3 = a[4:2];
    if (a[7:5] != 3'd0) return 32'h0;
    if (RO[i3]) return ro_value();
    return model[i3];
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    logic [2:0]  i3;
    logic [31:0] m;
    i3 = a[4:2];
    m  = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (a[7:5] != 3'd0) begin
      resp = 2'b10;
    end else if (RO[i3]) begin
`ifdef PLZWORK_AXIL_W1C_EN
      sticky = (sticky & ~(d & m)) | hw7;
      exp_pulse[i3]++;
      resp = 2'b00;
`else
      resp = 2'b10;
`endif
    end else begin
      model[i3] = (model[i3] & ~m) | (d & m);
      exp_pulse[i3]++;
      resp = 2'b00;
    end
  endtask

  task automatic wait_b(input string tag, output logic [1:0] resp);
    bit got;
    got  = 1'b0;
    resp = 2'bxx;
    bready = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      if (bvalid) begin
        resp = bresp;
        got  = 1'b1;
      end
      @(posedge clk); #1;
    end
    check({tag, "_b_arrived"}, 64'(got), 64'(1));
  endtask

  task automatic axi_write(input string tag, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_done, w_done, hs_aw, hs_w;
    aw_done = 1'b0;
    w_done  = 1'b0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk); #1;
      if (hs_aw) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (hs_w)  begin w_done  = 1'b1; wvalid  = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check({tag, "_aw_w_accepted"}, 64'(aw_done && w_done), 64'(1));
    wait_b(tag, resp);
  endtask

  task automatic axi_read(input string tag, input logic [7:0] a,
                          output logic [31:0] d, output logic [1:0] resp);
    bit done, got, hs;
    done = 1'b0;
    got  = 1'b0;
    d = 'x; resp = 'x;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      hs = arready;
      @(posedge clk); #1;
      if (hs) begin done = 1'b1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (rvalid) begin d = rdata; resp = rresp; got = 1'b1; end
      @(posedge clk); #1;
    end
    check({tag, "_r_arrived"}, 64'(done && got), 64'(1));
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] got, exp;
    axi_write(tag, a, d, s, got);
    model_write(a, d, s, exp);
    check({tag, "_bresp"}, 64'(got), 64'(exp));
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(tag, a, d, r);
    check({tag, "_rdata"}, 64'(d), 64'(model_read(a)));
    check({tag, "_rresp"}, 64'(r), (a[7:5] != 3'd0) ? 64'(2) : 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, e1, e2;
    logic [31:0] d, old, nd;
    logic [7:0]  a;
    int          p2;

    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    hw7 = '0; hw_other = '0; sticky = '0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    rst_n = 1'b0;
    #200;
    rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_awready", 64'(awready), 64'(1));
    check("rst_wready", 64'(wready), 64'(1));
    check("rst_arready", 64'(arready), 64'(1));
    check("rst_bvalid", 64'(bvalid), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_bresp", 64'(bresp), 64'(0));
    check("rst_rresp", 64'(rresp), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_pulse", 64'(reg_wr_pulse), 64'(0));
    check("rst_reg_out_lo", reg_out[63:0], 64'(0));
    for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_rd%0d", i), 8'(i * 4));

`ifndef PLZWORK_AXIL_W1C_EN
    hw7 = 32'hA5A5A5A5;
`endif
    for (int i = 0; i < 7; i++) hw_other[i*32 +: 32] = $urandom;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) wr_chk($sformatf("seq_wr%0d", i), 8'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("seq_rd%0d", i), 8'(i * 4));
    for (int i = 0; i < 8; i++) check($sformatf("seq_pulse%0d", i), 64'(pulse_cnt[i]), 64'(exp_pulse[i]));

    wr_chk("strb_full", 8'h00, 32'h12345678, 4'hF);
    wr_chk("strb_part", 8'h00, 32'hFFFFFFFF, 4'b0101);
    axi_read("strb_rd", 8'h00, d, resp);
    check("strb_value", 64'(d), 64'(32'h12FF56FF));
    check("strb_model", 64'(d), 64'(model_read(8'h00)));

    for (int n = 0; n < 24; n++) begin
      a = (n % 6 == 5) ? 8'($urandom) : 8'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
      wr_chk($sformatf("rnd_wr%0d", n), a, $urandom, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 12; i++) rd_chk($sformatf("rnd_rd%0d", i), 8'(i * 4 + $urandom_range(0, 3)));

    // Read and write of the same register on the same edge.
    check("same_edge_idle", 64'(awready && wready && arready), 64'(1));
    old = model[1];
    nd  = $urandom;
    awaddr = 8'h04; wdata = nd; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    araddr = 8'h04; arvalid = 1; rready = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("same_edge_rvalid", 64'(rvalid), 64'(1));
    check("same_edge_old_data", 64'(rdata), 64'(old));
    check("same_edge_bvalid", 64'(bvalid), 64'(1));
    model_write(8'h04, nd, 4'hF, e1);
    check("same_edge_bresp", 64'(bresp), 64'(e1));
    @(posedge clk); #1;
    rd_chk("same_edge_after", 8'h04);

    // W three cycles ahead of AW, then B stalled for five cycles with a second write parked.
    p2 = pulse_cnt[2];
    bready = 0;
    wdata = $urandom; wstrb = 4'hF; wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0;
    model_write(8'h08, wdata, 4'hF, e1);
    repeat (2) @(posedge clk);
    #1;
    check("ord_w_parked", 64'(wready), 64'(0));
    awaddr = 8'h08; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    check("ord_bvalid", 64'(bvalid), 64'(1));
    check("ord_bresp", 64'(bresp), 64'(e1));
    awaddr = 8'h0C; wdata = $urandom; wstrb = 4'b1010; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    check("ord_awready_low", 64'(awready), 64'(0));
    check("ord_wready_low", 64'(wready), 64'(0));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("ord_hold_bvalid%0d", c), 64'(bvalid), 64'(1));
      check($sformatf("ord_hold_bresp%0d", c), 64'(bresp), 64'(e1));
    end
    check("ord_once", 64'(pulse_cnt[2]), 64'(p2 + 1));
    bready = 1;
    @(posedge clk); #1;
    model_write(8'h0C, wdata, 4'b1010, e2);
    check("ord_second_bvalid", 64'(bvalid), 64'(1));
    check("ord_second_bresp", 64'(bresp), 64'(e2));
    check("ord_ready_back", 64'(awready && wready), 64'(1));
    @(posedge clk); #1;
    check("ord_bvalid_drop", 64'(bvalid), 64'(0));
    rd_chk("ord_rd2", 8'h08);
    rd_chk("ord_rd3", 8'h0C);

    axi_write("err_oor", 8'h20, 32'hDEADBEEF, 4'hF, resp);
    check("err_oor_slverr", 64'(resp), 64'(2));
    rd_chk("err_oor_rd", 8'h20);
    wr_chk("err_ro_wr", 8'h1C, 32'h00000010, 4'hF);
    rd_chk("err_ro_rd", 8'h1C);
`ifndef PLZWORK_AXIL_W1C_EN
    check("err_ro_slverr", 64'(bresp), 64'(2));
    check("err_ro_reg_out", 64'(reg_out[7*32 +: 32]), 64'(32'hA5A5A5A5));
`else
    hw7 = 32'h1;
    @(posedge clk); #1;
    hw7 = 32'h0;
    sticky = sticky | 32'h1;
    rd_chk("w1c_set", 8'h1C);
    wr_chk("w1c_clear", 8'h1C, 32'h1, 4'hF);
    rd_chk("w1c_cleared", 8'h1C);
    awaddr = 8'h1C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1; hw7 = 32'h1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; hw7 = 32'h0;
    wait_b("w1c_race", resp);
    check("w1c_race_bresp", 64'(resp), 64'(0));
    sticky = (sticky & ~32'h1) | 32'h1;
    exp_pulse[7]++;
    axi_read("w1c_race_rd", 8'h1C, d, resp);
    check("w1c_race_value", 64'(d), 64'(32'h1));
`endif

    for (int i = 0; i < 7; i++) check($sformatf("end_reg_out%0d", i), 64'(reg_out[i*32 +: 32]), 64'(model[i]));
    for (int i = 0; i < 8; i++) check($sformatf("end_pulse%0d", i), 64'(pulse_cnt[i]), 64'(exp_pulse[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
